sb_rx: RTL and testbench

- Sideband receiver. It is the downstream partner of SB_TX.
- Samples the serial sideband data pin and its gated clock strobe, and deserialises 64-bit sideband words, LSB first.
- Buffers completed words in a small FIFO and hands them to the sideband protocol layer over a valid/ready interface.
- Detects truncated words, short inter-packet gaps and buffer overflow.

---
 rtl/sb_rx.sv | 148 ++++++++++++++
 tb/tb_sb_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sb_rx.sv
// Sideband receiver: deserialises 64-bit LSB-first words from the strobed
// sideband pins and queues them in a small FIFO behind a valid/ready port.
module sb_rx #(
   parameter int buffer_size = 4,
   parameter int min_gap     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dataPin_i,
   input  logic        clkPin_i,
   input  logic        enable_i,
   output logic [63:0] data_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        overflow_o,
   output logic        frame_err_o,
   output logic        gap_err_o
);

   // state  | meaning
   // IDLE   | waiting for the first strobe of a packet, counting idle cycles
   // SHIFT  | capturing bits 1..63 of the current word

   localparam int AW = $clog2(buffer_size);
   localparam int GW = $clog2(min_gap + 1);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t        r_state, w_state_nxt;
   logic [5:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic [63:0]   r_shift, w_shift_nxt;
   logic [GW-1:0] r_idle_cnt, w_idle_cnt_nxt;
   logic          r_word_done, w_word_done_nxt;
   logic          r_frame_err, w_frame_err_nxt;
   logic          r_gap_err, w_gap_err_nxt;
   logic          w_idle_sat;
   logic [GW-1:0] w_idle_inc;

   assign w_idle_sat = (r_idle_cnt == GW'(min_gap));
   assign w_idle_inc = w_idle_sat ? r_idle_cnt : r_idle_cnt + GW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_idle_cnt  <= GW'(min_gap);
         r_word_done <= 1'b0;
         r_frame_err <= 1'b0;
         r_gap_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_idle_cnt  <= w_idle_cnt_nxt;
         r_word_done <= w_word_done_nxt;
         r_frame_err <= w_frame_err_nxt;
         r_gap_err   <= w_gap_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_idle_cnt_nxt  = r_idle_cnt;
      w_word_done_nxt = 1'b0;
      w_frame_err_nxt = 1'b0;
      w_gap_err_nxt   = 1'b0;
      if (!enable_i) begin
         // Pins are ignored while disabled, but the quiet time still counts as gap.
         w_state_nxt    = ST_IDLE;
         w_bit_cnt_nxt  = '0;
         w_idle_cnt_nxt = w_idle_inc;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (clkPin_i) begin
                  w_shift_nxt[0] = dataPin_i;
                  w_bit_cnt_nxt  = 6'd1;
                  w_state_nxt    = ST_SHIFT;
                  w_gap_err_nxt  = !w_idle_sat;
               end else begin
                  w_idle_cnt_nxt = w_idle_inc;
               end
            end
            ST_SHIFT: begin
               if (clkPin_i) begin
                  w_shift_nxt[r_bit_cnt] = dataPin_i;
                  w_bit_cnt_nxt          = r_bit_cnt + 6'd1;
                  if (r_bit_cnt == 6'd63) begin
                     w_word_done_nxt = 1'b1;
                     w_idle_cnt_nxt  = '0;
                     w_state_nxt     = ST_IDLE;
                  end
               end else begin
                  w_bit_cnt_nxt   = '0;
                  w_idle_cnt_nxt  = GW'(1);
                  w_frame_err_nxt = 1'b1;
                  w_state_nxt     = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt   = ST_IDLE;
               w_bit_cnt_nxt = '0;
            end
         endcase
      end
   end

   logic [63:0]   r_mem [buffer_size];
   logic [AW-1:0] r_rd_ptr, r_wr_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic          w_push, w_pop, w_full, w_write;

   assign w_push  = r_word_done;
   assign w_pop   = valid_o && ready_i;
   assign w_full  = (r_count == (AW+1)'(buffer_size));
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign w_write = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < buffer_size; i++) r_mem[i] <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_write) begin
            r_mem[r_wr_ptr] <= r_shift;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_write && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (!w_write && w_pop) r_count <= r_count - (AW+1)'(1);
         if (w_push && !w_write) r_overflow <= 1'b1;
      end
   end

   assign data_o      = r_mem[r_rd_ptr];
   assign valid_o     = (r_count != '0);
   assign overflow_o  = r_overflow;
   assign frame_err_o = r_frame_err;
   assign gap_err_o   = r_gap_err;

endmodule

// File: tb/tb_sb_rx.sv
// Directed and randomized bench for sb_rx; a word-level queue model predicts
// FIFO contents, overflow and error pulse counts.
module tb_sb_rx;

   logic        clk = 1'b0;
   logic        reset, dataPin, clkPin, enable, ready;
   logic [63:0] data;
   logic        valid, ovf, ferr, gerr;

   sb_rx #(.buffer_size(4), .min_gap(32)) dut (
      .clk(clk), .reset(reset), .dataPin_i(dataPin), .clkPin_i(clkPin),
      .enable_i(enable), .data_o(data), .valid_o(valid), .ready_i(ready),
      .overflow_o(ovf), .frame_err_o(ferr), .gap_err_o(gerr)
   );

   always #5 clk = ~clk;

   int          n_tests = 0, n_fail = 0;
   int          n_ferr = 0, n_gerr = 0;
   logic [63:0] exp_q[$];
   logic        exp_ovf;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock edge; outputs sampled 1 time unit later, pulses tallied here.
   task automatic tick();
      @(posedge clk);
      #1;
      if (ferr === 1'b1) n_ferr++;
      if (gerr === 1'b1) n_gerr++;
   endtask

   task automatic idle(input int n);
      clkPin  = 1'b0;
      dataPin = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_bits(input logic [63:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         dataPin = w[i];
         clkPin  = 1'b1;
         tick();
      end
      clkPin  = 1'b0;
      dataPin = 1'b0;
   endtask

   task automatic model_push(input logic [63:0] w);
      if (exp_q.size() < 4) exp_q.push_back(w);
      else exp_ovf = 1'b1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      clkPin = 1'b0;
      tick();
      reset  = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) begin
         check({tag, "_valid"}, valid, 1);
         check({tag, "_data"}, data, exp_q[0]);
         ready = 1'b1;
         tick();
         ready = 1'b0;
         void'(exp_q.pop_front());
      end
      check({tag, "_empty"}, valid, 0);
      check({tag, "_ovf"}, ovf, exp_ovf);
   endtask

   initial begin
      logic [63:0] w [5];
      int          f0, g0, gap, exp_g;

      reset = 1'b0; dataPin = 1'b0; clkPin = 1'b0; enable = 1'b1; ready = 1'b0;
      exp_ovf = 1'b0;
      do_reset();
      check("rst_valid", valid, 0);
      check("rst_data", data, 64'h0);
      check("rst_ovf", ovf, 0);
      check("rst_ferr", ferr, 0);
      check("rst_gerr", gerr, 0);

      // Single word: valid appears on the second edge after the last bit.
      f0 = n_ferr; g0 = n_gerr;
      send_bits(64'h7473655465494355, 64);
      check("t1_valid_early", valid, 0);
      tick();
      check("t1_valid", valid, 1);
      check("t1_data", data, 64'h7473655465494355);
      check("t1_errs", 64'(n_ferr - f0 + n_gerr - g0), 0);
      ready = 1'b1; tick(); ready = 1'b0;
      check("t1_popped", valid, 0);

      // Three words queued with ready low, then popped in order.
      idle(32);
      g0 = n_gerr;
      send_bits(64'h7473655465494355, 64); model_push(64'h7473655465494355); idle(32);
      send_bits(64'h21676F6C69726556, 64); model_push(64'h21676F6C69726556); idle(32);
      send_bits(64'h3234494A6E65704F, 64); model_push(64'h3234494A6E65704F); tick();
      idle(3);
      check("t2_head_stable", data, 64'h7473655465494355);
      drain("t2");
      check("t2_gerr", 64'(n_gerr - g0), 0);

      // Overflow: fifth word dropped, sticky until reset.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         w[k] = {$urandom, $urandom};
         if (k > 0) idle(32);
         send_bits(w[k], 64);
         model_push(w[k]);
      end
      tick();
      check("t3_ovf", ovf, 1);
      idle(5);
      check("t3_ovf_hold", ovf, 1);
      drain("t3");
      do_reset();
      check("t3_ovf_cleared", ovf, 0);

      // Overflow avoided by a pop on the push edge of word 5.
      for (int k = 0; k < 5; k++) begin
         w[k] = {$urandom, $urandom};
         if (k > 0) idle(32);
         send_bits(w[k], 64);
         if (k < 4) model_push(w[k]);
      end
      check("t3b_head", data, exp_q[0]);
      ready = 1'b1; tick(); ready = 1'b0;
      void'(exp_q.pop_front());
      model_push(w[4]);
      check("t3b_no_ovf", ovf, 0);
      drain("t3b");

      // Truncation after 40 bits, then an intact word.
      idle(32);
      f0 = n_ferr; g0 = n_gerr;
      w[0] = {$urandom, $urandom};
      w[1] = {$urandom, $urandom};
      send_bits(w[0], 40);
      tick();
      check("t4_ferr_pulse", ferr, 1);
      idle(32);
      check("t4_no_push", valid, 0);
      send_bits(w[1], 64); model_push(w[1]); tick();
      check("t4_ferr_count", 64'(n_ferr - f0), 1);
      check("t4_gerr_count", 64'(n_gerr - g0), 0);
      drain("t4");

      // Gap violation: 10 idle cycles between packets.
      idle(32);
      f0 = n_ferr; g0 = n_gerr;
      w[0] = {$urandom, $urandom};
      w[1] = {$urandom, $urandom};
      send_bits(w[0], 64); model_push(w[0]);
      idle(10);
      send_bits(w[1], 64); model_push(w[1]); tick();
      check("t5_gerr_count", 64'(n_gerr - g0), 1);
      check("t5_ferr_count", 64'(n_ferr - f0), 0);
      drain("t5");

      // Disable at bit 20: partial word discarded silently.
      idle(32);
      f0 = n_ferr; g0 = n_gerr;
      w[0] = {$urandom, $urandom};
      w[1] = {$urandom, $urandom};
      send_bits(w[0], 20);
      enable = 1'b0;
      idle(5);
      enable = 1'b1;
      idle(32);
      check("t6_no_push", valid, 0);
      send_bits(w[1], 64); model_push(w[1]); tick();
      check("t6_errs", 64'(n_ferr - f0 + n_gerr - g0), 0);
      drain("t6");

      // Reset mid-word with two words queued.
      idle(32);
      w[0] = {$urandom, $urandom};
      w[1] = {$urandom, $urandom};
      w[2] = {$urandom, $urandom};
      send_bits(w[0], 64); idle(32);
      send_bits(w[1], 64); idle(32);
      check("t6b_queued", valid, 1);
      send_bits(w[2], 30);
      f0 = n_ferr; g0 = n_gerr;
      do_reset();
      check("t6b_valid", valid, 0);
      check("t6b_ovf", ovf, 0);
      send_bits(w[2], 64); model_push(w[2]); tick();
      check("t6b_errs", 64'(n_ferr - f0 + n_gerr - g0), 0);
      drain("t6b");

      // Randomized gaps with ready held high; gap error iff fewer than 32 idle cycles.
      idle(40);
      ready = 1'b1;
      g0 = n_gerr; exp_g = 0;
      for (int k = 0; k < 8; k++) begin
         gap = (k == 0) ? 0 : int'($urandom_range(5, 40));
         if (k > 0) begin
            idle(gap);
            // One extra idle cycle already elapsed on the push edge below.
            if (gap + 1 < 32) exp_g++;
         end
         w[0] = {$urandom, $urandom};
         send_bits(w[0], 64);
         tick();
         check("rnd_valid", valid, 1);
         check("rnd_data", data, w[0]);
      end
      idle(2);
      ready = 1'b0;
      check("rnd_drained", valid, 0);
      check("rnd_gerr_count", 64'(n_gerr - g0), 64'(exp_g));
      check("rnd_ovf", ovf, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
